cache_nway_wb_core: RTL and testbench

//  Self-contained N-way set-associative write-back cache: tag/valid/dirty/data arrays, tree pseudo-LRU, and an integrated controller FSM.

---
 rtl/cache_nway_wb_core.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_cache_nway_wb_core.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway_wb_core.sv
// N-way set-associative write-back cache with tree pseudo-LRU and an integrated controller.
// Line-granular on both the upstream and the downstream side.
module cache_nway_wb_core #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_index  = 3,
    parameter int unsigned s_tag    = 32 - s_offset - s_index,
    parameter int unsigned s_mask   = 2 ** s_offset,
    parameter int unsigned s_line   = 8 * s_mask,
    parameter int unsigned s_way    = 2,
    parameter int unsigned s_cnt    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                upstream_read,
    input  logic                upstream_write,
    input  logic [31:0]         upstream_address,
    input  logic [s_line-1:0]   upstream_wdata,
    input  logic [s_mask-1:0]   upstream_byte_enable,
    output logic [s_line-1:0]   upstream_rdata,
    output logic                upstream_resp,
    output logic                downstream_read,
    output logic                downstream_write,
    output logic [31:0]         downstream_address,
    output logic [s_line-1:0]   downstream_wdata,
    input  logic [s_line-1:0]   downstream_rdata,
    input  logic                downstream_resp,
    output logic [s_cnt-1:0]    hit_count,
    output logic [s_cnt-1:0]    miss_count
);

    localparam int unsigned num_ways = 2 ** s_way;
    localparam int unsigned num_sets = 2 ** s_index;
    localparam int unsigned plru_w   = num_ways - 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, WB, FILL} state_t;

    state_t state, state_next;

    logic [s_tag-1:0]   req_tag;
    logic [s_index-1:0] idx;
    logic               offset_unused;

    // Storage arrays
    logic [s_tag-1:0]    tag_arr   [num_sets][num_ways];
    logic [s_line-1:0]   data_arr  [num_sets][num_ways];
    logic [num_ways-1:0] valid_arr [num_sets];
    logic [num_ways-1:0] dirty_arr [num_sets];
    logic [plru_w-1:0]   plru_arr  [num_sets];

    // Registered read port
    logic [s_tag-1:0]    rd_tag  [num_ways];
    logic [s_line-1:0]   rd_data [num_ways];
    logic [num_ways-1:0] rd_valid;
    logic [num_ways-1:0] rd_dirty;
    logic [plru_w-1:0]   rd_plru;

    // Array write port
    logic                arr_we;
    logic [s_way-1:0]    arr_way;
    logic [s_tag-1:0]    arr_tag;
    logic [s_line-1:0]   arr_line;
    logic                arr_dirty;
    logic                plru_we;
    logic [plru_w-1:0]   plru_new;

    // Controller state and next values
    logic [s_way-1:0]    victim, victim_next;
    logic                relookup, relookup_next;
    logic                resp_next, dread_next, dwrite_next;
    logic [s_line-1:0]   rdata_next, dwdata_next;
    logic [31:0]         daddr_next;
    logic [s_cnt-1:0]    hits_next, misses_next;

    // Lookup helpers
    logic                hit, inv;
    logic [s_way-1:0]    hit_way, inv_way, vic_way;
    logic [s_line-1:0]   hit_line, wr_line;

    assign req_tag       = upstream_address[31 -: s_tag];
    assign idx           = upstream_address[s_offset +: s_index];
    assign offset_unused = ^upstream_address[s_offset-1:0];

    // Walk the PLRU tree along the pointer bits to the victim leaf
    function automatic logic [s_way-1:0] plru_victim(input logic [plru_w-1:0] bits);
        int unsigned n;
        n = 0;
        for (int unsigned l = 0; l < s_way; l++) begin
            n = 2 * n + 1 + 32'(1'(bits >> n));
        end
        return s_way'(n - plru_w);
    endfunction

    // Point every node on the path of an accessed way away from it
    function automatic logic [plru_w-1:0] plru_touch(input logic [plru_w-1:0] bits,
                                                     input logic [s_way-1:0] way);
        int unsigned n;
        logic dir;
        logic [plru_w-1:0] r;
        r = bits;
        n = 0;
        for (int unsigned l = 0; l < s_way; l++) begin
            dir = 1'(way >> (s_way - 1 - l));
            r   = (r & ~(plru_w'(1) << n)) | (plru_w'(!dir) << n);
            n   = 2 * n + 1 + 32'(dir);
        end
        return r;
    endfunction

    // Byte-masked merge of write data into a line
    function automatic logic [s_line-1:0] merge(input logic [s_line-1:0] old,
                                                input logic [s_line-1:0] wd,
                                                input logic [s_mask-1:0] be);
        logic [s_line-1:0] r;
        r = old;
        for (int unsigned b = 0; b < s_mask; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Valid, dirty and PLRU state, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(num_sets); s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            if (arr_we) begin
                valid_arr[idx][arr_way] <= 1'b1;
                dirty_arr[idx][arr_way] <= arr_dirty;
            end
            if (plru_we) plru_arr[idx] <= plru_new;
        end
    end

    // Tag and data storage
    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_arr[idx][arr_way]  <= arr_tag;
            data_arr[idx][arr_way] <= arr_line;
        end
    end

    // Synchronous read of the addressed set, forwarding a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= '0;
            rd_dirty <= '0;
            rd_plru  <= '0;
        end else begin
            rd_valid <= valid_arr[idx];
            rd_dirty <= dirty_arr[idx];
            rd_plru  <= plru_we ? plru_new : plru_arr[idx];
            if (arr_we) begin
                rd_valid[arr_way] <= 1'b1;
                rd_dirty[arr_way] <= arr_dirty;
            end
        end
    end

    // Tag/data read registers, forwarding a same-cycle write
    always_ff @(posedge clk) begin
        for (int w = 0; w < int'(num_ways); w++) begin
            rd_tag[w]  <= tag_arr[idx][w];
            rd_data[w] <= data_arr[idx][w];
        end
        if (arr_we) begin
            rd_tag[arr_way]  <= arr_tag;
            rd_data[arr_way] <= arr_line;
        end
    end

    // Controller state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            victim             <= '0;
            relookup           <= 1'b0;
            upstream_resp      <= 1'b0;
            upstream_rdata     <= '0;
            downstream_read    <= 1'b0;
            downstream_write   <= 1'b0;
            downstream_address <= '0;
            downstream_wdata   <= '0;
            hit_count          <= '0;
            miss_count         <= '0;
        end else begin
            state              <= state_next;
            victim             <= victim_next;
            relookup           <= relookup_next;
            upstream_resp      <= resp_next;
            upstream_rdata     <= rdata_next;
            downstream_read    <= dread_next;
            downstream_write   <= dwrite_next;
            downstream_address <= daddr_next;
            downstream_wdata   <= dwdata_next;
            hit_count          <= hits_next;
            miss_count         <= misses_next;
        end
    end

    // Next-state, array writes and next output values
    always_comb begin
        state_next    = state;
        victim_next   = victim;
        relookup_next = relookup;
        resp_next     = 1'b0;
        rdata_next    = upstream_rdata;
        dread_next    = downstream_read;
        dwrite_next   = downstream_write;
        daddr_next    = downstream_address;
        dwdata_next   = downstream_wdata;
        hits_next     = hit_count;
        misses_next   = miss_count;
        arr_we        = 1'b0;
        arr_way       = victim;
        arr_tag       = req_tag;
        arr_line      = downstream_rdata;
        arr_dirty     = 1'b0;
        plru_we       = 1'b0;
        plru_new      = rd_plru;
        hit           = 1'b0;
        hit_way       = '0;
        inv           = 1'b0;
        inv_way       = '0;

        // Descending scan leaves the lowest matching way selected
        for (int w = int'(num_ways) - 1; w >= 0; w--) begin
            if (rd_valid[w] && (rd_tag[w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = s_way'(w);
            end
            if (!rd_valid[w]) begin
                inv     = 1'b1;
                inv_way = s_way'(w);
            end
        end
        vic_way  = inv ? inv_way : plru_victim(rd_plru);
        hit_line = rd_data[hit_way];
        wr_line  = merge(hit_line, upstream_wdata, upstream_byte_enable);

        case (state)
            IDLE: begin
                relookup_next = 1'b0;
                // The cycle carrying resp still sees the completed request
                if ((upstream_read || upstream_write) && !upstream_resp) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    resp_next  = 1'b1;
                    rdata_next = upstream_write ? wr_line : hit_line;
                    plru_we    = 1'b1;
                    plru_new   = plru_touch(rd_plru, hit_way);
                    if (upstream_write) begin
                        arr_we    = 1'b1;
                        arr_way   = hit_way;
                        arr_line  = wr_line;
                        arr_dirty = 1'b1;
                    end
                    if (!relookup && (hit_count != '1)) hits_next = hit_count + s_cnt'(1);
                    relookup_next = 1'b0;
                    state_next    = IDLE;
                end else begin
                    victim_next = vic_way;
                    if (!relookup && (miss_count != '1)) misses_next = miss_count + s_cnt'(1);
                    if (rd_valid[vic_way] && rd_dirty[vic_way]) begin
                        dwrite_next = 1'b1;
                        daddr_next  = {rd_tag[vic_way], idx, {s_offset{1'b0}}};
                        dwdata_next = rd_data[vic_way];
                        state_next  = WB;
                    end else begin
                        dread_next = 1'b1;
                        daddr_next = {req_tag, idx, {s_offset{1'b0}}};
                        state_next = FILL;
                    end
                end
            end
            WB: begin
                if (downstream_resp) begin
                    dwrite_next = 1'b0;
                    dread_next  = 1'b1;
                    daddr_next  = {req_tag, idx, {s_offset{1'b0}}};
                    state_next  = FILL;
                end
            end
            FILL: begin
                if (downstream_resp) begin
                    arr_we        = 1'b1;
                    arr_way       = victim;
                    arr_line      = downstream_rdata;
                    arr_dirty     = 1'b0;
                    dread_next    = 1'b0;
                    relookup_next = 1'b1;
                    state_next    = LOOKUP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_nway_wb_core.sv
// Bench for cache_nway_wb_core: directed scenarios plus random traffic against a
// way-level behavioural cache model and a downstream memory responder.
module tb_cache_nway_wb_core;

    logic         clk = 1'b0;
    logic         rst;
    logic         upstream_read, upstream_write;
    logic [31:0]  upstream_address;
    logic [255:0] upstream_wdata;
    logic [31:0]  upstream_byte_enable;
    logic [255:0] upstream_rdata;
    logic         upstream_resp;
    logic         downstream_read, downstream_write;
    logic [31:0]  downstream_address;
    logic [255:0] downstream_wdata;
    logic [255:0] downstream_rdata;
    logic         downstream_resp;
    logic [3:0]   hit_count, miss_count;

    always #5 clk = ~clk;

    cache_nway_wb_core #(.s_cnt(4)) dut (
        .clk(clk), .rst(rst),
        .upstream_read(upstream_read), .upstream_write(upstream_write),
        .upstream_address(upstream_address), .upstream_wdata(upstream_wdata),
        .upstream_byte_enable(upstream_byte_enable), .upstream_rdata(upstream_rdata),
        .upstream_resp(upstream_resp),
        .downstream_read(downstream_read), .downstream_write(downstream_write),
        .downstream_address(downstream_address), .downstream_wdata(downstream_wdata),
        .downstream_rdata(downstream_rdata), .downstream_resp(downstream_resp),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int checks = 0;
    int errors = 0;

    // Memory images: what the downstream responder holds and what the model expects it to hold
    logic [255:0] ds_mem [logic [31:0]];
    logic [255:0] m_mem  [logic [31:0]];

    // Cache model: per set, per way contents; PLRU as root/left/right pointer bits
    bit           m_valid [8][4];
    bit           m_dirty [8][4];
    logic [23:0]  m_tag   [8][4];
    logic [255:0] m_data  [8][4];
    bit   [2:0]   m_plru  [8];
    int           m_hits, m_misses;

    bit           e_hit, e_wb;
    logic [31:0]  e_wb_addr, e_fill_addr;
    logic [255:0] e_wb_data, e_line;

    bit           last_wb;
    logic [31:0]  last_wb_addr;
    logic [255:0] last_wb_data, last_rdata;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] gen_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = (a * 32'h9E37_79B9) ^ (32'h0101_0101 * i) ^ 32'h5A5A_0000;
        return l;
    endfunction

    function automatic logic [255:0] ds_get(input logic [31:0] a);
        if (ds_mem.exists(a)) return ds_mem[a];
        return gen_line(a);
    endfunction

    function automatic logic [255:0] m_get(input logic [31:0] a);
        if (m_mem.exists(a)) return m_mem[a];
        return gen_line(a);
    endfunction

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_plru[s] = 3'b000;
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    // One request as the cache should see it: hit/miss, write-back, fill, result line
    task automatic model_access(input bit wr, input logic [31:0] a, input logic [255:0] wd, input logic [31:0] be);
        int s, way;
        logic [23:0] t;
        bit [2:0] b;
        s = int'(a[7:5]);
        t = a[31:8];
        way = -1;
        for (int w = 0; w < 4; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
        e_hit = (way >= 0);
        e_wb = 1'b0;
        e_wb_addr = '0;
        e_wb_data = '0;
        e_fill_addr = '0;
        b = m_plru[s];
        if (e_hit) m_hits++;
        else begin
            m_misses++;
            for (int w = 3; w >= 0; w--) if (!m_valid[s][w]) way = w;
            if (way < 0) way = b[0] ? (b[2] ? 3 : 2) : (b[1] ? 1 : 0);
            if (m_valid[s][way] && m_dirty[s][way]) begin
                e_wb = 1'b1;
                e_wb_addr = {m_tag[s][way], 3'(s), 5'b0};
                e_wb_data = m_data[s][way];
                m_mem[e_wb_addr] = e_wb_data;
            end
            e_fill_addr = {a[31:5], 5'b0};
            m_data[s][way] = m_get(e_fill_addr);
            m_valid[s][way] = 1'b1;
            m_tag[s][way] = t;
            m_dirty[s][way] = 1'b0;
        end
        if (wr) begin
            for (int i = 0; i < 32; i++) if (be[i]) m_data[s][way][8*i +: 8] = wd[8*i +: 8];
            m_dirty[s][way] = 1'b1;
        end
        if (way < 2) begin
            b[0] = 1'b1;
            b[1] = (way == 0);
        end else begin
            b[0] = 1'b0;
            b[2] = (way == 2);
        end
        m_plru[s] = b;
        e_line = m_data[s][way];
    endtask

    // Issue one request, serve downstream traffic with random latency, check everything observed
    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [255:0] wd,
                           input logic [31:0] be, input string tag);
        bit done, saw_wb, saw_rd, both, rd_after_wb, pend;
        logic [31:0] wb_addr, rd_addr;
        logic [255:0] wb_data, got;
        int ncyc, dly;
        done = 0; saw_wb = 0; saw_rd = 0; both = 0; rd_after_wb = 0; pend = 0;
        wb_addr = '0; rd_addr = '0; wb_data = '0; got = '0; ncyc = 0; dly = 0;
        model_access(wr, a, wd, be);
        @(negedge clk);
        upstream_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        upstream_write = wr;
        upstream_address = a;
        upstream_wdata = wd;
        upstream_byte_enable = be;
        while (!done && ncyc < 200) begin
            @(negedge clk);
            ncyc++;
            if (downstream_read && downstream_write) both = 1;
            if (downstream_resp) downstream_resp = 1'b0;
            else if (downstream_write) begin
                if (!pend) begin
                    saw_wb = 1; wb_addr = downstream_address; wb_data = downstream_wdata;
                    pend = 1; dly = $urandom_range(0, 2);
                end
                if (dly == 0) begin
                    ds_mem[wb_addr] = wb_data; downstream_resp = 1'b1; pend = 0;
                end else dly--;
            end else if (downstream_read) begin
                if (!pend) begin
                    saw_rd = 1; rd_after_wb = saw_wb; rd_addr = downstream_address;
                    pend = 1; dly = $urandom_range(0, 2);
                end
                if (dly == 0) begin
                    downstream_rdata = ds_get(rd_addr); downstream_resp = 1'b1; pend = 0;
                end else dly--;
            end
            if (upstream_resp) begin
                done = 1;
                got = upstream_rdata;
                upstream_read = 1'b0;
                upstream_write = 1'b0;
            end
        end
        upstream_read = 1'b0;
        upstream_write = 1'b0;
        downstream_resp = 1'b0;
        last_wb = saw_wb; last_wb_addr = wb_addr; last_wb_data = wb_data; last_rdata = got;
        chk({tag, "_completed"}, 256'(done), 256'(1));
        chk({tag, "_rd_wr_overlap"}, 256'(both), 256'(0));
        chk({tag, "_writeback_seen"}, 256'(saw_wb), 256'(e_wb));
        if (e_wb) begin
            chk({tag, "_wb_addr"}, 256'(wb_addr), 256'(e_wb_addr));
            chk({tag, "_wb_data"}, wb_data, e_wb_data);
            chk({tag, "_wb_before_fill"}, 256'(rd_after_wb), 256'(1));
        end
        chk({tag, "_fill_seen"}, 256'(saw_rd), 256'(!e_hit));
        if (!e_hit) chk({tag, "_fill_addr"}, 256'(rd_addr), 256'(e_fill_addr));
        if (!wr) chk({tag, "_rdata"}, got, e_line);
        if (e_hit) chk({tag, "_hit_latency"}, 256'(ncyc), 256'(2));
        chk({tag, "_hit_count"}, 256'(hit_count), 256'(sat(m_hits)));
        chk({tag, "_miss_count"}, 256'(miss_count), 256'(sat(m_misses)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        upstream_read = 1'b0;
        upstream_write = 1'b0;
        downstream_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        logic [255:0] wd, ref_line;
        logic [31:0] a, be;
        bit seen;
        rst = 1'b1;
        upstream_read = 1'b0;
        upstream_write = 1'b0;
        upstream_address = '0;
        upstream_wdata = '0;
        upstream_byte_enable = '0;
        downstream_rdata = '0;
        downstream_resp = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state, sampled while reset is still held
        chk("rst_resp", 256'(upstream_resp), 256'(0));
        chk("rst_rdata", upstream_rdata, 256'(0));
        chk("rst_ds_read", 256'(downstream_read), 256'(0));
        chk("rst_ds_write", 256'(downstream_write), 256'(0));
        chk("rst_ds_addr", 256'(downstream_address), 256'(0));
        chk("rst_ds_wdata", downstream_wdata, 256'(0));
        chk("rst_hits", 256'(hit_count), 256'(0));
        chk("rst_misses", 256'(miss_count), 256'(0));
        rst = 1'b0;

        // Cold read miss, then a hit of the same line
        run_txn(1'b0, 32'h0000_0040, '0, '0, "cold_read");
        chk("cold_read_misses", 256'(miss_count), 256'(1));
        chk("cold_read_hits", 256'(hit_count), 256'(0));
        run_txn(1'b0, 32'h0000_0040, '0, '0, "warm_read");
        chk("warm_read_hits", 256'(hit_count), 256'(1));

        // Partial write of the low word, then read back
        wd = rand_line();
        wd[31:0] = 32'hDEAD_BEEF;
        run_txn(1'b1, 32'h0000_0040, wd, 32'h0000_000F, "low_word_write");
        run_txn(1'b0, 32'h0000_0044, '0, '0, "low_word_read");
        ref_line = gen_line(32'h0000_0040);
        chk("merged_low_bytes", 256'(last_rdata[31:0]), 256'(32'hDEAD_BEEF));
        chk("merged_upper_bytes", 256'(last_rdata[255:32]), 256'(ref_line[255:32]));

        // Fill set 2 with five lines: the fifth evicts the dirty 0x40 line
        run_txn(1'b1, 32'h0000_0140, rand_line(), 32'hFFFF_0000, "set2_write");
        run_txn(1'b0, 32'h0000_0240, '0, '0, "set2_fill_b");
        run_txn(1'b0, 32'h0000_0340, '0, '0, "set2_fill_c");
        run_txn(1'b0, 32'h0000_0440, '0, '0, "set2_evict");
        chk("evict_wb_seen", 256'(last_wb), 256'(1));
        chk("evict_wb_addr", 256'(last_wb_addr), 256'(32'h0000_0040));
        chk("evict_wb_low_word", 256'(last_wb_data[31:0]), 256'(32'hDEAD_BEEF));

        // Reset while a fill is outstanding
        @(negedge clk);
        upstream_read = 1'b1;
        upstream_address = 32'h0000_0540;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (downstream_read || downstream_write) begin
                seen = 1;
                break;
            end
        end
        chk("midfill_request_seen", 256'(downstream_read), 256'(1));
        rst = 1'b1;
        upstream_read = 1'b0;
        @(negedge clk);
        chk("midfill_rst_ds_read", 256'(downstream_read), 256'(0));
        chk("midfill_rst_ds_write", 256'(downstream_write), 256'(0));
        chk("midfill_rst_hits", 256'(hit_count), 256'(0));
        chk("midfill_rst_misses", 256'(miss_count), 256'(0));
        rst = 1'b0;
        model_reset();
        run_txn(1'b0, 32'h0000_0540, '0, '0, "post_rst_reread");
        chk("post_rst_reread_missed", 256'(miss_count), 256'(seen ? 1 : 0));

        // Random traffic over a few tags per set to force hits, evictions and write-backs
        for (int n = 0; n < 150; n++) begin
            a = {21'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 3'b000};
            a = {a[28:0], 3'($urandom_range(0, 7))};
            be = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            run_txn(1'($urandom_range(0, 1)), a, rand_line(), be, "random");
        end

        // Counter saturation: one miss followed by twenty hits
        do_reset();
        run_txn(1'b0, 32'h0000_0000, '0, '0, "sat_first");
        for (int n = 0; n < 20; n++) run_txn(1'b0, 32'(n % 32), '0, '0, "sat_hit");
        chk("sat_hit_count", 256'(hit_count), 256'(4'hF));
        chk("sat_miss_count", 256'(miss_count), 256'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
